// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready, held for
// WAIT_STATES cycles, byte-addressed little-endian storage with load extension.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        w_q;
  logic [2:0]  f3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] mem [DEPTH_WORDS];

  logic          accept, go_resp, commit;
  logic          a_write, a_err, misalign, oor, illegal;
  logic [2:0]    a_f3, lane;
  logic [1:0]    a_size;
  logic [63:0]   a_addr, a_wdata;
  logic [AW-1:0] widx;
  logic [7:0]    size_mask, bmask;
  logic [63:0]   rword, rshift, ldata, wshift, merged;

  assign accept  = req_valid && req_ready;
  assign go_resp = (accept && (WAIT_STATES == 0)) || ((state == WAIT) && (cnt == 4'd1));

  // With zero wait states the access resolves on the accept edge, so the live
  // request is used instead of the (not yet loaded) capture registers.
  always_comb begin
    a_write = (state == IDLE) ? req_write  : w_q;
    a_f3    = (state == IDLE) ? req_funct3 : f3_q;
    a_addr  = (state == IDLE) ? req_addr   : addr_q;
    a_wdata = (state == IDLE) ? req_wdata  : wdata_q;
    a_size  = a_f3[1:0];
    lane    = a_addr[2:0];
    widx    = a_addr[AW+2:3];

    unique case (a_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = a_addr[0];
      2'd2:    misalign = |a_addr[1:0];
      default: misalign = |a_addr[2:0];
    endcase
    oor     = a_addr[63:3] >= 61'(DEPTH_WORDS);
    illegal = a_write ? a_f3[2] : (a_f3 == 3'b111);
    a_err   = misalign | oor | illegal;

    rword  = mem[widx];
    rshift = rword >> {lane, 3'b000};
    unique case (a_size)
      2'd0:    ldata = a_f3[2] ? {56'd0, rshift[7:0]}  : {{56{rshift[7]}},  rshift[7:0]};
      2'd1:    ldata = a_f3[2] ? {48'd0, rshift[15:0]} : {{48{rshift[15]}}, rshift[15:0]};
      2'd2:    ldata = a_f3[2] ? {32'd0, rshift[31:0]} : {{32{rshift[31]}}, rshift[31:0]};
      default: ldata = rshift;
    endcase

    unique case (a_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    bmask  = size_mask << lane;
    wshift = a_wdata << {lane, 3'b000};
    merged = rword;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bmask[i]) merged[i*8 +: 8] = wshift[i*8 +: 8];
    end

    commit = go_resp && a_write && !a_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      w_q       <= 1'b0;
      f3_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          w_q       <= req_write;
          f3_q      <= req_funct3;
          addr_q    <= req_addr;
          wdata_q   <= req_wdata;
          req_ready <= 1'b0;
          if (WAIT_STATES != 0) begin
            state <= WAIT;
            cnt   <= 4'(WAIT_STATES);
          end
        end
        WAIT: if (cnt != 4'd1) cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        state     <= RESP;
        cnt       <= '0;
        rsp_valid <= 1'b1;
        rsp_error <= a_err;
        rsp_rdata <= (a_err || a_write) ? '0 : ldata;
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) mem[widx] <= merged;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 5 wait states) checked
// against directed vectors and a byte-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [2:0]  req_funct3 [3];
  logic [63:0] req_addr [3];
  logic [63:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [63:0] rsp_rdata [3];
  logic        rsp_error [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mm [3][128];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 5))
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
      .req_funct3(req_funct3[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]), .rsp_error(rsp_error[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 5);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_req_ready%0d", tag, d), 64'(req_ready[d]), 64'd1);
      chk($sformatf("%s_rsp_valid%0d", tag, d), 64'(rsp_valid[d]), 64'd0);
      chk($sformatf("%s_rsp_rdata%0d", tag, d), rsp_rdata[d], 64'd0);
      chk($sformatf("%s_rsp_error%0d", tag, d), 64'(rsp_error[d]), 64'd0);
    end
  endtask

  // Reference: storage as bytes; size = 2**funct3[1:0]; little-endian assembly.
  task automatic model_txn(input int d, input bit w, input bit [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int size;
    size = 1 << f3[1:0];
    rd = '0;
    er = ((a % size) != 0) || ((a >> 3) >= DEPTH) || (w ? f3[2] : (f3 == 3'b111));
    if (!er) begin
      if (w) begin
        for (int i = 0; i < size; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = size - 1; i >= 0; i--) rd = (rd << 8) | 64'(mm[d][int'(a) + i]);
        if (!f3[2] && rd[8*size-1]) rd = rd | ~((64'd1 << (8*size)) - 64'd1);
      end
    end
  endtask

  task automatic run_txn(input int d, input bit w, input bit [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input int hold,
                         output logic [63:0] rd, output logic er);
    int lat;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1; req_write[d] = w; req_funct3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'($urandom); req_write[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
    req_addr[d] = {$urandom, $urandom}; req_wdata[d] = {$urandom, $urandom};
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      chk("req_ready_busy", 64'(req_ready[d]), 64'd0);
      if (rsp_valid[d]) lat = k;
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: dut %0d got no rsp_valid within 40 cycles, required %0d", d, ws_of(d) + 1);
      req_valid[d] = 1'b0;
      rd = '0; er = 1'b0;
      return;
    end
    chk($sformatf("latency_dut%0d", d), 64'(lat), 64'(ws_of(d) + 1));
    rd = rsp_rdata[d];
    er = rsp_error[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid[d]), 64'd1);
      chk("bp_rdata", rsp_rdata[d], rd);
      chk("bp_error", 64'(rsp_error[d]), 64'(er));
      chk("bp_req_ready", 64'(req_ready[d]), 64'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("post_hs_req_ready", 64'(req_ready[d]), 64'd1);
    chk("post_hs_rsp_valid", 64'(rsp_valid[d]), 64'd0);
  endtask

  typedef struct {
    bit          w;
    bit [2:0]    f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          hold;
    logic [63:0] exp_rd;
    bit          exp_er;
  } vec_t;

  vec_t vec [13];
  logic [63:0] rd, mrd;
  logic er, mer;

  initial begin
    vec[0]  = '{1'b1, 3'b011, 64'h10,  64'h1122334455667788, 0,  64'h0, 1'b0};
    vec[1]  = '{1'b0, 3'b011, 64'h10,  64'h0,                0,  64'h1122334455667788, 1'b0};
    vec[2]  = '{1'b0, 3'b000, 64'h10,  64'h0,                0,  64'hFFFFFFFFFFFFFF88, 1'b0};
    vec[3]  = '{1'b0, 3'b100, 64'h10,  64'h0,                0,  64'h88, 1'b0};
    vec[4]  = '{1'b0, 3'b001, 64'h16,  64'h0,                0,  64'h1122, 1'b0};
    vec[5]  = '{1'b1, 3'b000, 64'h13,  64'hAB,               0,  64'h0, 1'b0};
    vec[6]  = '{1'b0, 3'b011, 64'h10,  64'h0,                10, 64'h11223344AB667788, 1'b0};
    vec[7]  = '{1'b0, 3'b010, 64'h12,  64'h0,                0,  64'h0, 1'b1};
    vec[8]  = '{1'b1, 3'b011, 64'h0,   64'h0123456789ABCDEF, 0,  64'h0, 1'b0};
    vec[9]  = '{1'b1, 3'b011, 64'h800, 64'hFFFFFFFFFFFFFFFF, 0,  64'h0, 1'b1};
    vec[10] = '{1'b0, 3'b111, 64'h0,   64'h0,                0,  64'h0, 1'b1};
    vec[11] = '{1'b1, 3'b110, 64'h0,   64'hFFFFFFFFFFFFFFFF, 0,  64'h0, 1'b1};
    vec[12] = '{1'b0, 3'b011, 64'h0,   64'h0,                3,  64'h0123456789ABCDEF, 1'b0};

    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
      for (int b = 0; b < 128; b++) mm[d][b] = 8'h00;
    end

    #1 reset_n = 1'b0;
    #2 chk_reset("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int d = 0; d < 3; d++)
      for (int wi = 0; wi < 16; wi++) run_txn(d, 1'b1, 3'b011, 64'(wi * 8), 64'h0, 0, rd, er);

    foreach (vec[i]) begin
      model_txn(0, vec[i].w, vec[i].f3, vec[i].addr, vec[i].wdata, mrd, mer);
      run_txn(0, vec[i].w, vec[i].f3, vec[i].addr, vec[i].wdata, vec[i].hold, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rd);
      chk($sformatf("vec%0d_error", i), 64'(er), 64'(vec[i].exp_er));
    end

    // Reset while a store sits in WAIT: it must never reach storage.
    run_txn(0, 1'b0, 3'b011, 64'h10, 64'h0, 0, rd, er);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b011;
    req_addr[0] = 64'h20; req_wdata[0] = 64'hDEAD;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid_in_wait_ready", 64'(req_ready[0]), 64'd0);
    reset_n = 1'b0;
    #1 chk_reset("mid");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_txn(0, 1'b0, 3'b011, 64'h20, 64'h0, 0, rd, er);
    chk("abort_ld_rdata", rd, 64'h0);
    chk("abort_ld_error", 64'(er), 64'd0);

    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 40; t++) begin
        bit w;
        bit [2:0] f3;
        logic [63:0] a, wd;
        w  = 1'($urandom);
        f3 = 3'($urandom);
        wd = {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) a = 64'h800 + 64'($urandom_range(0, 4000));
        else                           a = 64'($urandom_range(0, 127));
        model_txn(d, w, f3, a, wd, mrd, mer);
        run_txn(d, w, f3, a, wd, $urandom_range(0, 3), rd, er);
        chk($sformatf("rnd_d%0d_t%0d_rdata", d, t), rd, mrd);
        chk($sformatf("rnd_d%0d_t%0d_error", d, t), 64'(er), 64'(mer));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
